serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Parallel-to-serial bit-pattern generator that drives the one-bit serial input of the team's Moore sequence detectors. It accepts a word and a bit count over a valid/ready handshake, then shifts the bits out MSB-first, one bit per `bit_en` strobe. A Moore FSM sequences the transfer, and a one-cycle `done` pulse ends each pattern. It sits between the test/stimulus controller and any serial-input FSM.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits, legal range 2..32.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  a pattern is offered.
- `load_ready`  out  1  block can accept a pattern; high only in IDLE.
- `load_data`  in  WIDTH  pattern bits, right-aligned; bit `len-1` is sent first.
- `load_len`  in  LEN_W  number of bits to send. 0 and values above WIDTH both mean WIDTH.
- `bit_en`  in  1  pacing strobe; advances one bit per cycle in which it is high.
- `bout`  out  1  serial data, driven to the detector's serial input.
- `bout_valid`  out  1  `bout` carries a pattern (or parity) bit.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, PAR (parity, only with the macro), DONE. All outputs decode from registered state (Moore).
- IDLE:
  - `load_ready`=1.
  - On `load_valid`: capture `load_data` into the shift register, left-aligned so the first bit sits at the MSB.
  - Load the remaining count `cnt` with the effective length.
  - Clear the parity accumulator.
  - Go to SHIFT.
- SHIFT:
  - `bout` = shift-register MSB; `bout_valid`=1.
  - On `bit_en`: XOR `bout` into parity, shift left, and decrement `cnt`.
  - When `bit_en` is high and `cnt`==1, go to PAR if the macro is defined, else to DONE.
- PAR: `bout` = even-parity bit; `bout_valid`=1. On `bit_en`, go to DONE.
- DONE:
  - `done`=1; `bout`=0; `bout_valid`=0; `load_ready`=0.
  - Unconditionally go to IDLE next cycle.
- Idle line level: `bout`=0 whenever `bout_valid`=0.
- `load_valid` outside IDLE is ignored, and its data is not captured.
- `load_data` bits at or above the effective length are ignored.
- `bit_en` in IDLE or DONE has no effect.
- `cnt` is LEN_W bits wide and never wraps; it decrements only in SHIFT, from its effective length down to 1.

## Timing
- Reset values: `load_ready`=1, `bout`=0, `bout_valid`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0, shift register 0.
- Reset has priority over every other input. Asserting reset mid-transfer returns the block to IDLE at the next edge, drops the pattern and clears all outputs to their reset values. No `done` pulse is produced.
- Handshake: the load is accepted at the edge where `load_valid` and `load_ready` are both high. The first bit appears on `bout` in the following cycle.
- With `bit_en` held high, an N-bit pattern occupies cycles 1..N after acceptance:
  - parity (if enabled) in cycle N+1;
  - `done` in the next cycle;
  - `load_ready` high the cycle after that.
- Each bit is held until the edge on which `bit_en` is sampled high. `bit_en` low stalls the stream indefinitely.
- Back-to-back throughput: the next pattern is accepted at the earliest in the IDLE cycle after DONE.

## Configuration
- `SERIAL_PATTERN_GEN_PARITY_EN`:
  - Defined: the PAR state exists, and one even-parity bit (XOR of all sent bits) follows the data. Total serial length is N+1.
  - Undefined: PAR is not built, and SHIFT goes directly to DONE. Total serial length is N.

## Structure
- Shared package `serial_pattern_pkg` holds:
  - the state encoding (IDLE=0, SHIFT=1, PAR=2, DONE=3) as a 2-bit typedef;
  - the WIDTH default;
  - the effective-length function that maps 0 or >WIDTH to WIDTH.
- Sub-module `serial_pattern_shreg` holds:
  - the left-aligned load;
  - the MSB tap;
  - shift-on-enable;
  - the down-counter with its last-bit flag.
- The top level holds the FSM, parity register and output decode.

## Test plan
- WIDTH=8, macro off, `bit_en`=1: load `load_data`=0b1011 with `load_len`=4.
  - `bout` reads 1,0,1,1 in cycles 1–4.
  - `done`=1 in cycle 5; `load_ready`=1 in cycle 6.
- Macro on, same stimulus: `bout` reads 1,0,1,1, then a parity bit of 1 in cycle 5. `done`=1 in cycle 6.
- `bit_en` high every 3rd cycle, `load_data`=0xA5, `load_len`=0:
  - 8 bits 1,0,1,0,0,1,0,1 are sent, each held 3 cycles;
  - `busy` stays high throughout;
  - `done` pulses exactly once.
- Reset asserted while the 2nd bit of 0xFF/8 is on the line:
  - next cycle `bout`=0, `bout_valid`=0, `busy`=0, `load_ready`=1;
  - no `done` pulse.
- `load_valid` held high with changing data during SHIFT: the first pattern completes unchanged, and the next value is accepted only in IDLE.
- Generator output feeding the Moore sequence detector, pattern 0b0110, len 4: the detector output matches the golden model cycle for cycle.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the serial pattern generator.
// Optional parity stage: SERIAL_PATTERN_GEN_PARITY_EN.
package serial_pattern_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Zero or an over-long request both mean a full-width pattern.
  function automatic logic [31:0] eff_len(
    input logic [31:0] len,
    input int unsigned width
  );
    if (len == 32'd0 || len > 32'(width))
      return 32'(width);
    return len;
  endfunction

endpackage

// File: rtl/serial_pattern_shreg.sv
// Left-aligning shift register with bit down-counter.
// Used by serial_pattern_gen (SERIAL_PATTERN_GEN_PARITY_EN aware top).
module serial_pattern_shreg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             msb,
  output logic             last
);

  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] shamt;

  // Unused high bits fall off the top, first bit lands at the MSB.
  assign shamt = LEN_W'(WIDTH) - len;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data << shamt;
      cnt <= len;
    end else if (shift) begin
      sr <= sr << 1;
      if (cnt != '0)
        cnt <= cnt - LEN_W'(1);
    end
  end

  assign msb  = sr[WIDTH-1];
  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/serial_pattern_gen.sv
// MSB-first parallel-to-serial pattern generator (Moore FSM).
// Define SERIAL_PATTERN_GEN_PARITY_EN to append an even-parity bit.
module serial_pattern_gen
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             bit_en,
  output logic             bout,
  output logic             bout_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [LEN_W-1:0] len_eff;
  logic             load;
  logic             shift;
  logic             msb;
  logic             last;

  assign len_eff = LEN_W'(eff_len(32'(load_len), WIDTH));
  assign load    = (state == ST_IDLE) && load_valid;
  assign shift   = (state == ST_SHIFT) && bit_en;

  serial_pattern_shreg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (load_data),
    .len   (len_eff),
    .msb   (msb),
    .last  (last)
  );

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset)
      par <= 1'b0;
    else if (load)
      par <= 1'b0;
    else if (shift)
      par <= par ^ msb;
  end

  assign bout = bout_valid & ((state == ST_PAR) ? par : msb);
`else
  assign bout = bout_valid & msb;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_ready <= 1'b1;
      bout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state      <= ST_SHIFT;
            load_ready <= 1'b0;
            bout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_en && last) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            state      <= ST_PAR;
`else
            state      <= ST_DONE;
            bout_valid <= 1'b0;
            done       <= 1'b1;
`endif
          end
        end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        ST_PAR: begin
          if (bit_en) begin
            state      <= ST_DONE;
            bout_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state      <= ST_IDLE;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b1;
          bout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen (WIDTH=8).
// Follows SERIAL_PATTERN_GEN_PARITY_EN when defined.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic       bit_en;
  logic       bout;
  logic       bout_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int det      = 0;
  logic [3:0] win;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .bit_en     (bit_en),
    .bout       (bout),
    .bout_valid (bout_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(load_ready), 1);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_valid"}, 32'(bout_valid), 0);
    chk({tag, "_bout"},  32'(bout), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // period 0 = random bit_en, else bit_en high once every period cycles
  task automatic run(input logic [7:0] d, input logic [3:0] l,
                     input int period, input bit hold);
    logic q[$];
    logic p;
    int n;
    int k;
    n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    p = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      q.push_back(d[i]);
      p ^= d[i];
    end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    q.push_back(p);
`endif
    win = 4'd0;
    chk("accept_ready", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = l;
    bit_en     = 1'($urandom_range(0, 1));
    tick;
    load_valid = hold;
    k = 0;
    while (q.size() > 0 && k < 400) begin
      if (hold) begin
        load_data = 8'($urandom);
        load_len  = 4'($urandom);
      end
      if (period == 0)
        bit_en = 1'($urandom_range(0, 1));
      else
        bit_en = ((k % period) == period - 1);
      chk("sh_bout",  32'(bout), 32'(q[0]));
      chk("sh_valid", 32'(bout_valid), 1);
      chk("sh_busy",  32'(busy), 1);
      chk("sh_ready", 32'(load_ready), 0);
      chk("sh_done",  32'(done), 0);
      if (bit_en) begin
        win = {win[2:0], bout};
        if (win == 4'b0110)
          det++;
        void'(q.pop_front());
      end
      tick;
      k++;
    end
    chk("stream_bound", 32'(q.size()), 0);
    bit_en = 1'($urandom_range(0, 1));
    chk("dn_done",  32'(done), 1);
    chk("dn_valid", 32'(bout_valid), 0);
    chk("dn_bout",  32'(bout), 0);
    chk("dn_busy",  32'(busy), 1);
    chk("dn_ready", 32'(load_ready), 0);
    tick;
    chk_idle("post");
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_len   = 4'd0;
    bit_en     = 1'b0;
    tick;
    tick;
    chk_idle("rst");
    reset = 1'b0;

    // bit_en in IDLE does nothing
    for (int i = 0; i < 4; i++) begin
      bit_en = 1'($urandom_range(0, 1));
      tick;
      chk_idle("idle_en");
    end

    run(8'b0000_1011, 4'd4, 1, 1'b0);
    run(8'hA5, 4'd0, 3, 1'b0);
    run(8'hF3, 4'd1, 2, 1'b0);
    run(8'h5C, 4'd12, 1, 1'b0);

    // held load_valid: accepted only in IDLE, stream unaffected
    run(8'h96, 4'd6, 0, 1'b1);
    run(8'h3D, 4'd5, 1, 1'b1);
    load_valid = 1'b0;

    // reset while 2nd bit of 0xFF/8 is on the line
    load_valid = 1'b1;
    load_data  = 8'hFF;
    load_len   = 4'd8;
    bit_en     = 1'b1;
    tick;
    load_valid = 1'b0;
    tick;
    chk("rst_mid_bit", 32'(bout), 1);
    chk("rst_mid_valid", 32'(bout_valid), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_idle("rst_mid");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk_idle("rst_after");
    end

    // detector fed by the generator sees 0110 exactly once
    det = 0;
    run(8'b0000_0110, 4'd4, 1, 1'b0);
    chk("det_count", 32'(det), 1);

    for (int r = 0; r < 10; r++) begin
      run(8'($urandom), 4'($urandom),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      load_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
